// File: rtl/route_compute_pipe.sv
// rtl/route_compute_pipe.sv - per-channel registered route compute with eject counter
// Optional wrap-around routing is built when ROUTE_TORUS_EN is defined.
module route_compute_pipe #(
   parameter int X_W    = 2,
   parameter int Y_W    = 2,
   parameter int NUM_CH = 4,
   parameter int CNT_W  = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [X_W-1:0]        addrx,
   input  logic [Y_W-1:0]        addry,
   input  logic [X_W-1:0]        addrx_max,
   input  logic [Y_W-1:0]        addry_max,
   input  logic [NUM_CH-1:0]     in_valid,
   output logic [NUM_CH-1:0]     in_ready,
   input  logic [NUM_CH*X_W-1:0] in_destx,
   input  logic [NUM_CH*Y_W-1:0] in_desty,
   output logic [NUM_CH-1:0]     out_valid,
   input  logic [NUM_CH-1:0]     out_ready,
   output logic [NUM_CH*4-1:0]   rmatrix,
   output logic [NUM_CH-1:0]     resource_go,
   output logic [NUM_CH-1:0]     out_err,
   input  logic                  cnt_clr,
   output logic [CNT_W-1:0]      eject_cnt
);

   localparam int INC_W = $clog2(NUM_CH + 1) + 1;
   localparam int SUM_W = CNT_W + INC_W;
   localparam logic [SUM_W-1:0] CNT_MAX = {{INC_W{1'b0}}, {CNT_W{1'b1}}};

   logic [NUM_CH-1:0] w_accept;
   logic [INC_W-1:0]  w_inc;
   logic [SUM_W-1:0]  w_sum;
   logic [CNT_W-1:0]  r_cnt;

   assign in_ready = ~out_valid | out_ready;
   assign w_accept = in_valid & in_ready;

   genvar c;
   generate
      for (c = 0; c < NUM_CH; c++) begin : g_ch
         logic [X_W-1:0] w_dx;
         logic [Y_W-1:0] w_dy;
         logic           w_e, w_w, w_s, w_n;
         logic           w_err, w_go;
         logic           r_v, r_g, r_e;
         logic [3:0]     r_rm;

         assign w_dx = in_destx[c*X_W +: X_W];
         assign w_dy = in_desty[c*Y_W +: Y_W];

`ifdef ROUTE_TORUS_EN
         // Ring distances need one extra bit so that max+1 is representable.
         localparam logic [X_W:0] X_ONE = {{X_W{1'b0}}, 1'b1};
         localparam logic [Y_W:0] Y_ONE = {{Y_W{1'b0}}, 1'b1};
         logic [X_W:0] w_xsize, w_de, w_dw;
         logic [Y_W:0] w_ysize, w_ds, w_dn;

         assign w_xsize = {1'b0, addrx_max} + X_ONE;
         assign w_ysize = {1'b0, addry_max} + Y_ONE;
         assign w_de = (w_dx >= addrx) ? ({1'b0, w_dx} - {1'b0, addrx})
                                       : ({1'b0, w_dx} + w_xsize - {1'b0, addrx});
         assign w_ds = (w_dy >= addry) ? ({1'b0, w_dy} - {1'b0, addry})
                                       : ({1'b0, w_dy} + w_ysize - {1'b0, addry});
         assign w_dw = w_xsize - w_de;
         assign w_dn = w_ysize - w_ds;
         assign w_e  = (w_de != '0) && (w_de <= w_dw);
         assign w_w  = (w_de != '0) && (w_de >  w_dw);
         assign w_s  = (w_ds != '0) && (w_ds <= w_dn);
         assign w_n  = (w_ds != '0) && (w_ds >  w_dn);
`else
         assign w_e = w_dx > addrx;
         assign w_w = w_dx < addrx;
         assign w_s = w_dy > addry;
         assign w_n = w_dy < addry;
`endif

         assign w_err = (w_dx > addrx_max) || (w_dy > addry_max);
         assign w_go  = !w_err && (w_dx == addrx) && (w_dy == addry);

         always_ff @(posedge clk) begin
            if (rst) begin
               r_v  <= 1'b0;
               r_rm <= 4'b0000;
               r_g  <= 1'b0;
               r_e  <= 1'b0;
            end else if (w_accept[c]) begin
               r_v  <= 1'b1;
               r_rm <= w_err ? 4'b0000 : {w_w, w_e, w_s, w_n};
               r_g  <= w_go;
               r_e  <= w_err;
            end else if (out_ready[c]) begin
               r_v  <= 1'b0;
            end
         end

         assign out_valid[c]       = r_v;
         assign rmatrix[c*4 +: 4]  = r_rm;
         assign resource_go[c]     = r_g;
         assign out_err[c]         = r_e;
      end
   endgenerate

   always_comb begin
      w_inc = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         w_inc = w_inc + INC_W'(out_valid[i] & out_ready[i] & resource_go[i]);
      end
   end

   assign w_sum = SUM_W'(r_cnt) + SUM_W'(w_inc);

   // Clear takes priority over any ejects retiring in the same cycle.
   always_ff @(posedge clk) begin
      if (rst || cnt_clr) begin
         r_cnt <= '0;
      end else if (w_sum >= CNT_MAX) begin
         r_cnt <= '1;
      end else begin
         r_cnt <= w_sum[CNT_W-1:0];
      end
   end

   assign eject_cnt = r_cnt;

endmodule
